// File: rtl/surf_event_merger_if.sv
// Byte-wide AXI4-Stream bundle carrying N parallel lanes; tdata lane i is [8*i +: 8].
// The master side drives payload and valid/last, the slave side drives ready.
interface surf_event_merger_if #(
    parameter int N = 1
);
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tvalid;
    logic [N-1:0]   tlast;
    logic [N-1:0]   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/surf_event_merger.sv
// Merges one tlast-terminated frame per enabled SURF into a single tagged event stream.
// Define SURF_MERGE_FOOTER_EN to append an XOR checksum footer byte to every event.
module surf_event_merger #(
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sysclk_i,
    input  logic                 sysclk_rstn_i,
    input  logic [6:0]           surf_enable_i,
    surf_event_merger_if.slave   s_dout,
    surf_event_merger_if.master  m_ev,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] event_count_o,
    output logic [CNT_WIDTH-1:0] timeout_count_o
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_DATA,
        ST_FTR
    } state_t;

    state_t               state_reg, state_next;
    logic [6:0]           mask_reg, mask_next;
    logic [2:0]           sel_reg, sel_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic                 tmo_reg, tmo_next;
    logic [7:0]           out_data_reg, out_data_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 out_last_reg, out_last_next;
    logic [CNT_WIDTH-1:0] ev_cnt_reg, ev_cnt_next;
    logic [CNT_WIDTH-1:0] to_cnt_reg, to_cnt_next;
`ifdef SURF_MERGE_FOOTER_EN
    logic [7:0]           xor_reg, xor_next;
`endif

    logic       can_load;
    logic       sel_valid;
    logic       sel_last;
    logic [7:0] sel_data;
    logic [6:0] above_mask;
    logic       has_next;
    logic [2:0] first_sel;
    logic [2:0] next_sel;
    logic       load;
    logic [7:0] load_byte;
    logic       load_last;
    logic       end_frame;

    // The output register may take a new byte when empty or when its byte leaves this cycle.
    assign can_load  = !out_valid_reg || m_ev.tready[0];
    assign sel_valid = s_dout.tvalid[sel_reg];
    assign sel_last  = s_dout.tlast[sel_reg];
    assign sel_data  = s_dout.tdata[{sel_reg, 3'b000} +: 8];
    assign has_next  = |above_mask;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_lane
            assign above_mask[gi]    = mask_reg[gi] && (sel_reg < 3'(gi));
            assign s_dout.tready[gi] = (state_reg == ST_DATA) && (sel_reg == 3'(gi)) && can_load;
        end
    endgenerate

    // Lowest set bit of the live enable mask and of the SURFs still pending this event.
    always_comb begin
        first_sel = 3'd0;
        next_sel  = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (surf_enable_i[i]) first_sel = 3'(i);
            if (above_mask[i])    next_sel  = 3'(i);
        end
    end

    always_comb begin
        state_next     = state_reg;
        mask_next      = mask_reg;
        sel_next       = sel_reg;
        timer_next     = timer_reg;
        tmo_next       = tmo_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        ev_cnt_next    = ev_cnt_reg;
        to_cnt_next    = to_cnt_reg;
`ifdef SURF_MERGE_FOOTER_EN
        xor_next       = xor_reg;
`endif
        load      = 1'b0;
        load_byte = 8'h00;
        load_last = 1'b0;
        end_frame = 1'b0;

        if (out_valid_reg && m_ev.tready[0]) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            if (out_last_reg && (ev_cnt_reg != '1)) ev_cnt_next = ev_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if ((surf_enable_i != 7'd0) && s_dout.tvalid[first_sel]) begin
                    mask_next  = surf_enable_i;
                    sel_next   = first_sel;
                    timer_next = '0;
                    tmo_next   = 1'b0;
`ifdef SURF_MERGE_FOOTER_EN
                    xor_next   = 8'h00;
`endif
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A byte arriving on the expiry cycle still counts as a live SURF.
                if (sel_valid) begin
                    tmo_next   = 1'b0;
                    state_next = ST_HDR;
                end else if (timer_reg == TIMER_MAX) begin
                    tmo_next   = 1'b1;
                    state_next = ST_HDR;
                    if (to_cnt_reg != '1) to_cnt_next = to_cnt_reg + 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_HDR: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = {4'hA, tmo_reg, sel_reg};
                    if (tmo_reg) end_frame  = 1'b1;
                    else         state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (can_load && sel_valid) begin
                    load      = 1'b1;
                    load_byte = sel_data;
                    end_frame = sel_last;
                end
            end
`ifdef SURF_MERGE_FOOTER_EN
            ST_FTR: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_byte  = xor_reg;
                    load_last  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        if (end_frame) begin
            if (has_next) begin
                sel_next   = next_sel;
                timer_next = '0;
                tmo_next   = 1'b0;
                state_next = ST_WAIT;
            end else begin
`ifdef SURF_MERGE_FOOTER_EN
                state_next = ST_FTR;
`else
                load_last  = 1'b1;
                state_next = ST_IDLE;
`endif
            end
        end

        if (load) begin
            out_data_next  = load_byte;
            out_valid_next = 1'b1;
            out_last_next  = load_last;
`ifdef SURF_MERGE_FOOTER_EN
            xor_next       = xor_reg ^ load_byte;
`endif
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            state_reg     <= ST_IDLE;
            mask_reg      <= 7'd0;
            sel_reg       <= 3'd0;
            timer_reg     <= '0;
            tmo_reg       <= 1'b0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            ev_cnt_reg    <= '0;
            to_cnt_reg    <= '0;
`ifdef SURF_MERGE_FOOTER_EN
            xor_reg       <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            mask_reg      <= mask_next;
            sel_reg       <= sel_next;
            timer_reg     <= timer_next;
            tmo_reg       <= tmo_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            ev_cnt_reg    <= ev_cnt_next;
            to_cnt_reg    <= to_cnt_next;
`ifdef SURF_MERGE_FOOTER_EN
            xor_reg       <= xor_next;
`endif
        end
    end

    assign m_ev.tdata      = out_data_reg;
    assign m_ev.tvalid[0]  = out_valid_reg;
    assign m_ev.tlast[0]   = out_last_reg;
    assign busy_o          = (state_reg != ST_IDLE);
    assign event_count_o   = ev_cnt_reg;
    assign timeout_count_o = to_cnt_reg;
endmodule

// File: tb/tb_surf_event_merger.sv
// Directed bench for surf_event_merger: per-SURF source queues, output capture, immediate-assert checks.
// Compile with SURF_MERGE_FOOTER_EN defined to check the footer variant.
module tb_surf_event_merger;
    localparam int TIMEOUT   = 16;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [6:0]           enable;
    logic                 busy;
    logic [CNT_WIDTH-1:0] ev_cnt;
    logic [CNT_WIDTH-1:0] to_cnt;

    always #5 clk = ~clk;

    surf_event_merger_if #(.N(7)) s_if ();
    surf_event_merger_if #(.N(1)) m_if ();

    surf_event_merger #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .sysclk_i        (clk),
        .sysclk_rstn_i   (rst_n),
        .surf_enable_i   (enable),
        .s_dout          (s_if),
        .m_ev            (m_if),
        .busy_o          (busy),
        .event_count_o   (ev_cnt),
        .timeout_count_o (to_cnt)
    );

    logic [8:0] src_q [7][$];   // {tlast, byte} per SURF
    logic [8:0] exp_q[$];
    logic [8:0] out_q[$];
    int         out_cyc[$];
    logic [8:0] remnant[$];
    logic [7:0] exp_xor;
    logic [7:0] hold_data;
    bit         hold_pending, rand_ready, saw_r1;
    int         cycle, n_cmp, n_bad, lasts_seen, onehot_err, stab_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void src_push(input int s, input logic [7:0] d, input bit l);
        src_q[s].push_back({l, d});
    endfunction

    function automatic void exp_begin();
        exp_q.delete();
        exp_xor = 8'h00;
    endfunction

    function automatic void exp_push(input logic [7:0] d);
        exp_q.push_back({1'b0, d});
        exp_xor = exp_xor ^ d;
    endfunction

    function automatic void exp_end();
        logic [8:0] t;
`ifdef SURF_MERGE_FOOTER_EN
        exp_q.push_back({1'b1, exp_xor});
`else
        t = exp_q.pop_back();
        t[8] = 1'b1;
        exp_q.push_back(t);
`endif
    endfunction

    // One clock: present sources, settle, record handshakes, then advance past the edge.
    task automatic step();
        for (int i = 0; i < 7; i++) begin
            if (src_q[i].size() > 0) begin
                s_if.tvalid[i]       = 1'b1;
                s_if.tdata[8*i +: 8] = src_q[i][0][7:0];
                s_if.tlast[i]        = src_q[i][0][8];
            end else begin
                s_if.tvalid[i]       = 1'b0;
                s_if.tdata[8*i +: 8] = 8'h00;
                s_if.tlast[i]        = 1'b0;
            end
        end
        if (rand_ready) m_if.tready[0] = 1'($urandom_range(0, 1));
        #1;
        if ($countones(s_if.tready) > 1) onehot_err++;
        if (s_if.tready[1]) saw_r1 = 1'b1;
        if (hold_pending && (!m_if.tvalid[0] || m_if.tdata !== hold_data)) stab_err++;
        hold_pending = m_if.tvalid[0] && !m_if.tready[0];
        hold_data    = m_if.tdata;
        for (int i = 0; i < 7; i++)
            if (s_if.tready[i] && s_if.tvalid[i]) void'(src_q[i].pop_front());
        if (m_if.tvalid[0] && m_if.tready[0]) begin
            out_q.push_back({m_if.tlast[0], m_if.tdata});
            out_cyc.push_back(cycle);
            if (m_if.tlast[0]) lasts_seen++;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic wait_lasts(input string tag, input int target, input int budget);
        int n = 0;
        while (lasts_seen < target && n < budget) begin
            step();
            n++;
        end
        chk({tag, " event end seen"}, lasts_seen, target);
    endtask

    task automatic compare_event(input string tag);
        int bad = -1;
        chk({tag, " length"}, out_q.size(), exp_q.size());
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
            if (bad < 0 && out_q[k] !== exp_q[k]) bad = k;
        chk({tag, " first bad byte index"}, bad, -1);
        out_q.delete();
        out_cyc.delete();
    endtask

    initial begin
        int gap, target, len;
        rst_n = 1'b0;
        enable = 7'h00;
        s_if.tdata = '0;
        s_if.tvalid = '0;
        s_if.tlast = '0;
        m_if.tready = 1'b1;
        repeat (3) step();
        chk("reset m_tvalid", m_if.tvalid, 0);
        chk("reset m_tlast", m_if.tlast, 0);
        chk("reset m_tdata", m_if.tdata, 0);
        chk("reset s_tready", s_if.tready, 0);
        chk("reset busy", busy, 0);
        chk("reset event_count", ev_cnt, 0);
        chk("reset timeout_count", to_cnt, 0);
        rst_n = 1'b1;
        step();

        // Test 1: single SURF, three bytes; footer A0^11^22^33 = A0.
        enable = 7'h01;
        src_push(0, 8'h11, 0); src_push(0, 8'h22, 0); src_push(0, 8'h33, 1);
        exp_q.delete();
`ifdef SURF_MERGE_FOOTER_EN
        exp_q = '{9'h0A0, 9'h011, 9'h022, 9'h033, 9'h1A0};
`else
        exp_q = '{9'h0A0, 9'h011, 9'h022, 9'h133};
`endif
        wait_lasts("t1", 1, 200);
        compare_event("t1");
        chk("t1 event_count", ev_cnt, 1);
        chk("t1 busy after event", busy, 0);

        // Test 2: SURF0 and SURF2; SURF1 is never addressed.
        enable = 7'h05;
        saw_r1 = 1'b0;
        src_push(0, 8'h01, 1);
        src_push(2, 8'h02, 0); src_push(2, 8'h03, 1);
        exp_begin();
        exp_push(8'hA0); exp_push(8'h01); exp_push(8'hA2); exp_push(8'h02); exp_push(8'h03);
        exp_end();
        wait_lasts("t2", 2, 200);
        compare_event("t2");
        chk("t2 tready[1] ever high", saw_r1, 0);
        chk("t2 event_count", ev_cnt, 2);

        // Test 3: SURF1 silent; WAIT runs TIMEOUT cycles, HDR then loads the A9 header.
        enable = 7'h03;
        src_push(0, 8'h55, 1);
        exp_begin();
        exp_push(8'hA0); exp_push(8'h55); exp_push(8'hA9);
        exp_end();
        wait_lasts("t3", 3, 200);
        gap = (out_cyc.size() >= 3) ? out_cyc[2] - out_cyc[1] : -1;
        chk("t3 cycles from last SURF0 byte to A9", gap, TIMEOUT + 1);
        compare_event("t3");
        chk("t3 timeout_count", to_cnt, 1);
        chk("t3 event_count", ev_cnt, 3);

        // Test 4: all SURFs, random frame lengths, random downstream ready.
        enable = 7'h7F;
        rand_ready = 1'b1;
        stab_err = 0;
        for (int e = 0; e < 20; e++) begin
            exp_begin();
            for (int s = 0; s < 7; s++) begin
                len = $urandom_range(1, 64);
                exp_push(8'hA0 | 8'(s));
                for (int b = 0; b < len; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    src_push(s, d, b == len - 1);
                    exp_push(d);
                end
            end
            exp_end();
            target = lasts_seen + 1;
            wait_lasts("t4", target, 4000);
            compare_event("t4");
        end
        rand_ready = 1'b0;
        m_if.tready = 1'b1;
        step();
        chk("t4 output held while stalled", stab_err, 0);
        chk("t4 event_count", ev_cnt, 23);
        chk("t4 timeout_count", to_cnt, 1);

        // Test 5: reset while SURF3 is mid-frame.
        src_push(0, 8'h10, 1); src_push(1, 8'h20, 1); src_push(2, 8'h30, 1);
        for (int b = 0; b < 10; b++) src_push(3, 8'h31 + 8'(b), b == 9);
        for (int s = 4; s < 7; s++) src_push(s, 8'h40 + 8'(s), 1);
        begin
            int n = 0;
            while (out_q.size() < 9 && n < 200) begin
                step();
                n++;
            end
        end
        chk("t5 reached SURF3 data", out_q.size() >= 9, 1);
        chk("t5 SURF3 header", (out_q.size() > 6) ? out_q[6] : 9'h1FF, 9'h0A3);
        rst_n = 1'b0;
        #1;
        chk("t5 reset m_tvalid", m_if.tvalid, 0);
        chk("t5 reset m_tlast", m_if.tlast, 0);
        chk("t5 reset m_tdata", m_if.tdata, 0);
        chk("t5 reset s_tready", s_if.tready, 0);
        chk("t5 reset busy", busy, 0);
        chk("t5 reset event_count", ev_cnt, 0);
        chk("t5 reset timeout_count", to_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        hold_pending = 1'b0;
        out_q.delete();
        out_cyc.delete();
        lasts_seen = 0;
        remnant = src_q[3];
        for (int s = 4; s < 7; s++) src_q[s].delete();
        enable = 7'h09;
        src_push(0, 8'h5A, 1);
        exp_begin();
        exp_push(8'hA0); exp_push(8'h5A); exp_push(8'hA3);
        foreach (remnant[k]) exp_push(remnant[k][7:0]);
        exp_end();
        wait_lasts("t5 post-reset", 1, 300);
        compare_event("t5 post-reset");
        chk("t5 event_count", ev_cnt, 1);
        chk("t5 timeout_count", to_cnt, 0);

        // Test 6: test 1 stimulus again (footer variant when the macro is defined).
        enable = 7'h01;
        src_push(0, 8'h11, 0); src_push(0, 8'h22, 0); src_push(0, 8'h33, 1);
        exp_q.delete();
`ifdef SURF_MERGE_FOOTER_EN
        exp_q = '{9'h0A0, 9'h011, 9'h022, 9'h033, 9'h1A0};
`else
        exp_q = '{9'h0A0, 9'h011, 9'h022, 9'h133};
`endif
        wait_lasts("t6", 2, 200);
        compare_event("t6");
        chk("t6 event_count", ev_cnt, 2);

        chk("source ready one-hot", onehot_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
